// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a small byte-wide register file: write via index byte + data bytes,
// read continuing from the retained pointer. SCL/SDA are oversampled on CLK.
module i2c_slave_regs #(
  parameter logic [6:0]  DEVICE_ADDR = 7'b1000111,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDX_W      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCL,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic [NUM_REGS*8-1:0] REG_OUT,
  output logic                  WR_STROBE,
  output logic [IDX_W-1:0]      WR_IDX,
  output logic [7:0]            WR_DATA,
  output logic                  BUSY
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StIdx, StIdxAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_e             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic               rw_q, rw_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];
  logic               sda_oe_q, sda_oe_d, wr_strobe_q, wr_strobe_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]         wr_data_q, wr_data_d, rx_byte;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // Both SCL samples high so an SDA change during an SCL edge is not taken as START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + IDX_W'(1);

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], SCL};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    regs_d      = regs_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        StAddr, StIdx: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == StIdx) begin
              ptr_d    = shift_q[IDX_W-1:0];
              sda_oe_d = 1'b1;
              state_d  = StIdxAck;
            end else if (shift_q[7:1] == DEVICE_ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              state_d  = StAddrAck;
            end else begin
              state_d  = StIdle;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = StRdata;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StIdx;
            end
          end
        end
        StIdxAck, StWdataAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            state_d   = StWdata;
          end
        end
        StWdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              regs_d[ptr_q] = rx_byte;
              wr_strobe_d   = 1'b1;
              wr_idx_d      = ptr_q;
              wr_data_d     = rx_byte;
              ptr_d         = ptr_inc;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            state_d   = StWdataAck;
          end
        end
        StRdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = StRdataAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise && sda_s) begin
            state_d = StIdle;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            ptr_d     = ptr_inc;
            shift_d   = regs_q[ptr_inc];
            sda_oe_d  = ~regs_q[ptr_inc][7];
            state_d   = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      regs_q      <= regs_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign REG_OUT[8*i +: 8] = regs_q[i];
  end

  assign SDA_OE    = sda_oe_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_IDX    = wr_idx_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master on an open-drain SDA model.
module tb_i2c_slave_regs;
  localparam int Q = 5;  // CLKs per quarter SCL period

  logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic        sda_oe, wr_strobe, busy, sda_line;
  logic [31:0] reg_out;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;

  logic [9:0]  wlog[$];
  bit          oe_seen;
  int          n_checks = 0, n_errors = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regs dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .SCL      (scl),
    .SDA_IN   (sda_line),
    .SDA_OE   (sda_oe),
    .REG_OUT  (reg_out),
    .WR_STROBE(wr_strobe),
    .WR_IDX   (wr_idx),
    .WR_DATA  (wr_data),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) wlog.push_back({wr_idx, wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    b = sda_line; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_reg_out", reg_out, 32'h0);
    check_eq("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check_eq("rst_wr_idx", {30'd0, wr_idx}, 32'd0);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_q();

    // Two-byte write starting at index 1
    bus_start();
    send_byte(8'h8E, ack); check_eq("w_ack_addr", {31'd0, ack}, 32'd1);
    send_byte(8'h01, ack); check_eq("w_ack_idx", {31'd0, ack}, 32'd1);
    send_byte(8'hA5, ack); check_eq("w_ack_d0", {31'd0, ack}, 32'd1);
    send_byte(8'h5A, ack); check_eq("w_ack_d1", {31'd0, ack}, 32'd1);
    bus_stop();
    check_eq("w_strobe_cnt", wlog.size(), 32'd2);
    check_eq("w_strobe0", {22'd0, (wlog.size() > 0) ? wlog[0] : 10'h3ff}, {22'd0, 2'd1, 8'hA5});
    check_eq("w_strobe1", {22'd0, (wlog.size() > 1) ? wlog[1] : 10'h3ff}, {22'd0, 2'd2, 8'h5A});
    check_eq("w_reg_out", reg_out, 32'h005AA500);
    check_eq("w_busy_after_stop", {31'd0, busy}, 32'd0);

    // Fill all four registers; pointer wraps back to 0
    bus_start();
    send_byte(8'h8E, ack);
    send_byte(8'h00, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    send_byte(8'h33, ack);
    send_byte(8'h44, ack); check_eq("fill_ack_last", {31'd0, ack}, 32'd1);
    bus_stop();
    check_eq("fill_reg_out", reg_out, 32'h44332211);

    // Index 3, repeated START, read three bytes with wrap
    bus_start();
    send_byte(8'h8E, ack);
    send_byte(8'h03, ack); check_eq("r_ack_idx", {31'd0, ack}, 32'd1);
    bus_start();
    send_byte(8'h8F, ack); check_eq("r_ack_addr", {31'd0, ack}, 32'd1);
    recv_byte(1'b0, rd); check_eq("r_byte0", {24'd0, rd}, 32'h44);
    recv_byte(1'b0, rd); check_eq("r_byte1_wrap", {24'd0, rd}, 32'h11);
    recv_byte(1'b1, rd); check_eq("r_byte2", {24'd0, rd}, 32'h22);
    bus_stop();
    check_eq("r_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read with no index byte continues from retained ptr (1)
    bus_start();
    send_byte(8'h8F, ack);
    recv_byte(1'b1, rd); check_eq("r_ptr_retained", {24'd0, rd}, 32'h22);
    bus_stop();

    // Address mismatch
    wlog.delete();
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h90, ack); check_eq("mis_no_ack", {31'd0, ack}, 32'd0);
    check_eq("mis_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    check_eq("mis_oe_seen", {31'd0, oe_seen}, 32'd0);
    check_eq("mis_no_strobe", wlog.size(), 32'd0);
    check_eq("mis_reg_out", reg_out, 32'h44332211);

    // STOP after 4 data bits: partial byte discarded
    bus_start();
    send_byte(8'h8E, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    check_eq("part_no_strobe", wlog.size(), 32'd0);
    check_eq("part_busy", {31'd0, busy}, 32'd0);
    check_eq("part_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("part_reg_out", reg_out, 32'h44332211);

    // Reset mid-write, then a clean write
    bus_start();
    send_byte(8'h8E, ack);
    send_byte(8'h02, ack);
    send_byte(8'hAB, ack);
    check_eq("rw_pre_reg_out", reg_out, 32'h44AB2211);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rw_rst_reg_out", reg_out, 32'h0);
    check_eq("rw_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rw_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rw_rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check_eq("rw_rst_wr_data", {24'd0, wr_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wlog.delete();
    // Bus activity after reset without START must be ignored
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check_eq("rw_ignore_busy", {31'd0, busy}, 32'd0);
    bus_start();
    send_byte(8'h8E, ack); check_eq("rw_ack_addr", {31'd0, ack}, 32'd1);
    send_byte(8'h00, ack);
    send_byte(8'h7F, ack); check_eq("rw_ack_data", {31'd0, ack}, 32'd1);
    bus_stop();
    check_eq("rw_reg_out", reg_out, 32'h0000007F);
    check_eq("rw_strobe_cnt", wlog.size(), 32'd1);
    check_eq("rw_strobe0", {22'd0, (wlog.size() > 0) ? wlog[0] : 10'h3ff}, {22'd0, 2'd0, 8'h7F});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'b1000111, 7-bit slave address matched against the first byte after START.
REQ-002 SHALL have parameter NUM_REGS, default 4, register-file depth; power of two, 2..256; IDX_W = max(1, log2(NUM_REGS)).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on SCL and SDA_IN, range 2..4.
REQ-004 SHALL have port CLK, input, 1, sole clock; all state is updated on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port SCL, input, 1, asynchronous I2C clock pin.
REQ-007 SHALL have port SDA_IN, input, 1, asynchronous I2C data pin level.
REQ-008 SHALL have port SDA_OE, output, 1, registered; 1 = pull SDA low, 0 = release.
REQ-009 SHALL have port REG_OUT, output, NUM_REGS*8, flattened register file; reg[i] is REG_OUT[8i+7:8i].
REQ-010 SHALL have port WR_STROBE, output, 1, one-CLK pulse per committed data byte.
REQ-011 SHALL have port WR_IDX, output, IDX_W, register index of the committed byte; valid with WR_STROBE.
REQ-012 SHALL have port WR_DATA, output, 8, committed byte; valid with WR_STROBE.
REQ-013 SHALL have port BUSY, output, 1, high whenever state != IDLE.

Function
REQ-014 SHALL pass SCL and SDA_IN through SYNC_STAGES flops; edges SHALL be derived from the last two synchronised samples only.
REQ-015 SHALL decode START as SDA falling while SCL high, and STOP as SDA rising while SCL high; a START or STOP SHALL override any other event in the same cycle.
REQ-016 SHALL sample SDA on SCL rising edges only, MSB first, and SHALL change SDA_OE only on the CLK following a detected SCL falling edge.
REQ-017 SHALL implement the states IDLE, ADDR, ADDR_ACK, IDX, IDX_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK, with a 4-bit bit counter cleared on START and on every ACK slot.
REQ-018 SHALL go to ADDR on START from any state (repeated START included) and to IDLE with SDA_OE=0 on STOP from any state.
REQ-019 SHALL, in ADDR after 8 bits, on address match drive ACK (SDA_OE=1) for the 9th SCL period, then go to IDX if R/W=0 or RDATA if R/W=1; on mismatch SHALL go to IDLE with no ACK.
REQ-020 SHALL, in IDX after 8 bits, ACK, set ptr = byte mod NUM_REGS, and go to WDATA.
REQ-021 SHALL, in WDATA on the 8th sampled bit, write reg[ptr], pulse WR_STROBE with WR_IDX=ptr and WR_DATA=byte, and increment ptr modulo NUM_REGS (wrap NUM_REGS-1 -> 0); it SHALL then ACK and loop to WDATA.
REQ-022 SHALL, on entering RDATA, load reg[ptr] and drive SDA_OE = ~bit for each of 8 bits, then release SDA for the master ACK slot.
REQ-023 SHALL, on the master ACK slot in RDATA_ACK, on SDA=0 increment ptr with wrap, reload, and continue in RDATA, and on SDA=1 (NACK) go to IDLE.
REQ-024 SHALL retain ptr across STOP/START, so that a read without an index byte continues from the last ptr.
REQ-025 SHALL update WR_STROBE no more than once per byte; a START or STOP mid-byte SHALL discard the partial byte with no write.
REQ-026 SHALL operate correctly for CLK >= 10x SCL frequency.

Reset
REQ-027 SHALL, with RST_N=0 at a CLK edge, set state=IDLE, ptr=0, bit counter=0, all reg[i]=8'h00, SDA_OE=0, WR_STROBE=0, WR_IDX=0, WR_DATA=0, BUSY=0, and synchroniser flops to 1 (bus idle).
REQ-028 SHALL abandon any transaction in progress when reset is asserted mid-transaction, and SHALL ignore the bus after release until the next START.

Verification
REQ-029 SHALL pass: START, 0x8E, 0x01, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; WR_STROBE (idx1,0xA5), then (idx2,0x5A); REG_OUT=0x005AA500.
REQ-030 SHALL pass: START, 0x8E, 0x03, repeated START, 0x8F, master ACK, ACK, NACK, STOP, with regs {0x11,0x22,0x33,0x44} -> bytes read 0x44, 0x11 (wrap), 0x22; ptr=1 at end.
REQ-031 SHALL pass: START, 0x90 (address mismatch) -> SDA_OE never asserted, state IDLE, no WR_STROBE, REG_OUT unchanged.
REQ-032 SHALL pass: STOP after 4 bits of a data byte -> no write, BUSY=0, SDA_OE=0.
REQ-033 SHALL pass: RST_N=0 mid-write after 3 bytes -> all outputs at reset values next CLK; then a clean write of 0x8E, 0x00, 0x7F -> reg0=0x7F.
